// File: rtl/mdu_unit_if.sv
// Handshake and result bundle between the E-stage issue logic and the multiply/divide unit.
// master drives the operation request; slave (the MDU) returns busy, stall and HI/LO.
interface mdu_unit_if;
    logic        start;
    logic [2:0]  op;
    logic        op_sub;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_in_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, op_sub, cancel, a, b, md_in_d,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, op_sub, cancel, a, b, md_in_d,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/mdu_unit.sv
// MIPS E-stage multiply/divide unit: multi-cycle MULT/DIV into HI/LO, single-cycle MTHI/MTLO.
// Define MDU_MADD_EN to add signed MADD/MSUB (op=7) accumulating into HI/LO.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_unit_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic        load;
    logic [31:0] op_a, op_b;
    logic [2:0]  op_q;
    logic [31:0] hi_q, lo_q;
    logic        op_valid, is_long, is_div, accept, terminal;
    logic [63:0] prod_s, prod_u;
    logic [31:0] res_hi, res_lo;
    logic        res_we;
`ifdef MDU_MADD_EN
    logic        sub_q;
`endif

    // op=7 only decodes as a real operation when the accumulate feature is built in
    always_comb begin
        op_valid = 1'b0;
        is_long  = 1'b0;
        is_div   = 1'b0;
        case (bus.op)
            3'd1, 3'd2: begin op_valid = 1'b1; is_long = 1'b1; end
            3'd3, 3'd4: begin op_valid = 1'b1; is_long = 1'b1; is_div = 1'b1; end
            3'd5, 3'd6: op_valid = 1'b1;
`ifdef MDU_MADD_EN
            3'd7:       begin op_valid = 1'b1; is_long = 1'b1; end
`endif
            default:    ;
        endcase
    end

    assign accept       = bus.start && !bus.cancel && (state == IDLE) && op_valid;
    assign terminal     = (state == RUN) && (count == 4'd1);
    assign bus.busy     = (state == RUN);
    assign bus.stall_md = bus.md_in_d && ((state == RUN) || (bus.start && !bus.cancel && is_long));
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    always_comb begin
        state_next = state;
        count_next = count;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_long) begin
                    state_next = RUN;
                    load       = 1'b1;
                    count_next = is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            RUN: begin
                count_next = count - 4'd1;
                if (count == 4'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result of the latched operation, consumed only at the terminal edge
    always_comb begin
        prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
        prod_u = {32'd0, op_a} * {32'd0, op_b};
        res_hi = hi_q;
        res_lo = lo_q;
        res_we = 1'b0;
        case (op_q)
            3'd1: begin {res_hi, res_lo} = prod_s; res_we = 1'b1; end
            3'd2: begin {res_hi, res_lo} = prod_u; res_we = 1'b1; end
            3'd3: begin
                if (op_b != 32'd0) begin
                    res_we = 1'b1;
                    if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                        res_lo = 32'h8000_0000;
                        res_hi = 32'd0;
                    end else begin
                        res_lo = $signed(op_a) / $signed(op_b);
                        res_hi = $signed(op_a) % $signed(op_b);
                    end
                end
            end
            3'd4: begin
                if (op_b != 32'd0) begin
                    res_we = 1'b1;
                    res_lo = op_a / op_b;
                    res_hi = op_a % op_b;
                end
            end
`ifdef MDU_MADD_EN
            3'd7: begin
                {res_hi, res_lo} = sub_q ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
                res_we = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
            op_a  <= 32'd0;
            op_b  <= 32'd0;
            op_q  <= 3'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
`ifdef MDU_MADD_EN
            sub_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            count <= count_next;
            if (load) begin
                op_a <= bus.a;
                op_b <= bus.b;
                op_q <= bus.op;
`ifdef MDU_MADD_EN
                sub_q <= bus.op_sub;
`endif
            end
            if (terminal && res_we) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (accept && bus.op == 3'd5) begin
                hi_q <= bus.a;
            end else if (accept && bus.op == 3'd6) begin
                lo_q <= bus.a;
            end
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops against an arithmetic HI/LO model.
// Build with MDU_MADD_EN defined to exercise MADD/MSUB.
`timescale 1ns/1ps
module tb_mdu_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_unit_if bus();

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] m_hi, m_lo;
    int checks_total  = 0;
    int checks_passed = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        if (observed === expected) checks_passed++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    function automatic int expectedCycles(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return 5;
            3'd3, 3'd4: return 10;
`ifdef MDU_MADD_EN
            3'd7:       return 5;
`endif
            default:    return 0;
        endcase
    endfunction

    // Reference: architectural meaning of each op computed with 64-bit integer arithmetic
    task automatic modelOp(input logic [2:0] op, input logic sub, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin p = sa * sb; {m_hi, m_lo} = p; end
            3'd2: begin p = ua * ub; {m_hi, m_lo} = p; end
            3'd3: if (b != 32'd0) begin
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd4: if (b != 32'd0) begin
                p = ua / ub; m_lo = p[31:0];
                p = ua % ub; m_hi = p[31:0];
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
`ifdef MDU_MADD_EN
            3'd7: begin
                p = {m_hi, m_lo};
                p = sub ? (p - 64'(sa * sb)) : (p + 64'(sa * sb));
                {m_hi, m_lo} = p;
            end
`endif
            default: ;
        endcase
    endtask

    // Issues one op at posedge+1, then follows it to completion; inject pokes an MTHI mid-run
    task automatic applyStimulus(input logic [2:0] op, input logic sub, input logic [31:0] a,
                                 input logic [31:0] b, input logic md, input logic inject);
        int cycles;
        int n;
        logic [31:0] old_hi, old_lo;
        n = expectedCycles(op);
        old_hi = m_hi;
        old_lo = m_lo;
        bus.start = 1'b1; bus.op = op; bus.op_sub = sub; bus.a = a; bus.b = b;
        bus.md_in_d = md; bus.cancel = 1'b0;
        #1;
        checkOutput("stall_at_start", bus.stall_md, md && (n > 0));
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'd0;
        modelOp(op, sub, a, b);
        cycles = 0;
        while (bus.busy && cycles < 40) begin
            if (cycles == 0) begin
                checkOutput("hi_hold_run", bus.hi, old_hi);
                checkOutput("lo_hold_run", bus.lo, old_lo);
            end
            checkOutput("stall_in_run", bus.stall_md, md);
            if (inject && cycles == 1) begin
                bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0; bus.op = 3'd0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        bus.start = 1'b0; bus.op = 3'd0;
        checkOutput("busy_cycles", cycles, n);
        checkOutput("stall_after", bus.stall_md, 0);
        checkOutput("hi", bus.hi, m_hi);
        checkOutput("lo", bus.lo, m_lo);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start = 1'b0; bus.op = 3'd0; bus.op_sub = 1'b0; bus.cancel = 1'b0;
        bus.a = 32'd0; bus.b = 32'd0; bus.md_in_d = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_hi", bus.hi, 0);
        checkOutput("reset_lo", bus.lo, 0);
        checkOutput("reset_stall", bus.stall_md, 0);
        @(posedge clk); #1;

        applyStimulus(3'd1, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        checkOutput("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo_const", bus.lo, 32'hFFFF_FFFA);

        applyStimulus(3'd3, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        checkOutput("div_lo_const", bus.lo, 32'hFFFF_FFFD);
        checkOutput("div_hi_const", bus.hi, 32'hFFFF_FFFF);
        applyStimulus(3'd4, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        checkOutput("divu_lo_const", bus.lo, 32'h7FFF_FFFC);
        checkOutput("divu_hi_const", bus.hi, 32'd1);

        applyStimulus(3'd5, 1'b0, 32'h11, 32'd0, 1'b0, 1'b0);
        applyStimulus(3'd6, 1'b0, 32'h22, 32'd0, 1'b0, 1'b0);
        applyStimulus(3'd4, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0);
        checkOutput("div0_hi_const", bus.hi, 32'h11);
        checkOutput("div0_lo_const", bus.lo, 32'h22);

        applyStimulus(3'd3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checkOutput("divovf_lo_const", bus.lo, 32'h8000_0000);
        checkOutput("divovf_hi_const", bus.hi, 32'd0);

        // Cancelled start must leave no trace, then the same op proceeds
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd7; bus.b = 32'd9;
        bus.cancel = 1'b1; bus.md_in_d = 1'b1;
        #1 checkOutput("cancel_stall", bus.stall_md, 0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 3'd0;
        checkOutput("cancel_busy", bus.busy, 0);
        checkOutput("cancel_hi", bus.hi, m_hi);
        checkOutput("cancel_lo", bus.lo, m_lo);
        applyStimulus(3'd1, 1'b0, 32'd7, 32'd9, 1'b1, 1'b0);

        applyStimulus(3'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Reset in the third cycle of a DIV must discard the pending result
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7; bus.md_in_d = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'd0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        checkOutput("midreset_busy", bus.busy, 0);
        checkOutput("midreset_hi", bus.hi, 0);
        checkOutput("midreset_lo", bus.lo, 0);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (12) begin @(posedge clk); #1; end
        checkOutput("postreset_busy", bus.busy, 0);
        checkOutput("postreset_hi", bus.hi, 0);
        checkOutput("postreset_lo", bus.lo, 0);

`ifdef MDU_MADD_EN
        applyStimulus(3'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(3'd6, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0);
        applyStimulus(3'd7, 1'b0, 32'd3, 32'd4, 1'b1, 1'b0);
        checkOutput("madd_lo_const", bus.lo, 32'd22);
        applyStimulus(3'd7, 1'b1, 32'd5, 32'd5, 1'b1, 1'b0);
        checkOutput("msub_hi_const", bus.hi, 32'hFFFF_FFFF);
        checkOutput("msub_lo_const", bus.lo, 32'hFFFF_FFFD);
`else
        applyStimulus(3'd6, 1'b0, 32'h55, 32'd0, 1'b0, 1'b0);
        applyStimulus(3'd7, 1'b0, 32'd3, 32'd4, 1'b1, 1'b0);
        checkOutput("op7_noop_lo", bus.lo, 32'h55);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [2:0] rop;
            rop = 3'($urandom_range(1, 7));
            applyStimulus(rop, 1'($urandom_range(0, 1)), pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
